load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 REQ_VALID  input  1  request present.
REQ-005 REQ_READY  output  1  block can accept a request.
REQ-006 REQ_WRITE  input  1  1=store, 0=load.
REQ-007 REQ_SIZE  input  2  access size: 00=byte, 01=half, 10=word, 11=illegal.
REQ-008 REQ_SIGNED  input  1  sign-extend load data (ignored for word accesses and stores).
REQ-009 REQ_ADDR  input  32  byte address.
REQ-010 REQ_WDATA  input  32  store data, right-justified.
REQ-011 RSP_VALID  output  1  response present.
REQ-012 RSP_READY  input  1  consumer accepts the response.
REQ-013 RSP_RDATA  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 RSP_ERR  output  1  misaligned or illegal request.
REQ-015 MEM_WE  output  1  data memory write enable.
REQ-016 MEM_A  output  32  word address, equal to {2'b00, addr[31:2]}.
REQ-017 MEM_WD  output  32  data memory write data.
REQ-018 MEM_RD  input  32  data memory read data, valid the cycle after MEM_A is sampled (registered read).

Function
REQ-019 The state machine SHALL have the states IDLE, RD, WAIT, WR and RESP.
REQ-020 REQ_READY SHALL be 1 only in IDLE, and a request SHALL be accepted on a rising edge where REQ_VALID and REQ_READY are both 1.
REQ-021 On acceptance, REQ_WRITE, REQ_SIZE, REQ_SIGNED, REQ_ADDR and REQ_WDATA SHALL be latched, and later changes on the inputs SHALL NOT affect the operation.
REQ-022 An error SHALL be raised for size 11, half with addr[0]=1, or word with addr[1:0]!=00; on error the block SHALL go IDLE->RESP with RSP_ERR=1 and RSP_RDATA=0, and SHALL make no memory access.
REQ-023 A load SHALL follow IDLE->RD->WAIT->RESP, with RSP_VALID first high 3 cycles after acceptance.
REQ-024 A word store SHALL follow IDLE->WR->RESP, with RSP_VALID high 2 cycles after acceptance.
REQ-025 A byte or half store SHALL follow IDLE->RD->WAIT->WR->RESP (read-modify-write), with RSP_VALID high 4 cycles after acceptance.
REQ-026 MEM_A SHALL carry the latched word address in RD, WAIT and WR, and SHALL be 0 otherwise.
REQ-027 MEM_WE SHALL be 1 only in WR, and SHALL be 0 in any cycle where RST=1.
REQ-028 Byte lanes SHALL be little-endian: byte n occupies bits [8n+7:8n], and the lane is selected by addr[1:0] for bytes and by addr[1] for halves.
REQ-029 In WAIT, load data SHALL be extracted from MEM_RD, zero- or sign-extended per the latched REQ_SIGNED, and registered into RSP_RDATA.
REQ-030 For a sub-word store, MEM_WD in WR SHALL equal the MEM_RD captured in WAIT with only the selected lane replaced by the low bits of the latched REQ_WDATA; for a word store, MEM_WD SHALL equal REQ_WDATA.
REQ-031 In RESP, RSP_VALID SHALL be 1 and RSP_RDATA and RSP_ERR SHALL be held stable until RSP_READY=1; the block SHALL return to IDLE on that edge.
REQ-032 A new request SHALL NOT be accepted in the same cycle as a response handshake; back-to-back throughput is therefore one request per (latency+1) cycles minimum.
REQ-033 The address SHALL NOT be range-checked; the memory wraps or aliases upper bits itself.

Reset
REQ-034 On a rising edge with RST=1, state SHALL go to IDLE and RSP_VALID, RSP_ERR, RSP_RDATA and the latched registers SHALL clear to 0.
REQ-035 Reset in any state, including WR, SHALL abandon the operation without a memory write and without producing a response.
REQ-036 REQ_READY SHALL be 0 while RST=1 and 1 in the first cycle after RST falls.

Configuration
REQ-037 With macro LSU_SUBWORD_EN defined, the block SHALL provide byte and half support as specified above.
REQ-038 With LSU_SUBWORD_EN undefined, sizes 00 and 01 SHALL be treated as errors per REQ-022; the RD/WAIT path SHALL then serve word loads only, and the sub-word merge and extension logic SHALL be absent.

Verification
REQ-039 Word store of 0xDEADBEEF to address 0x10, then word load from 0x10 -> MEM_WE high for exactly 1 cycle with MEM_A=4, and the load returns RSP_RDATA=0xDEADBEEF, RSP_ERR=0, 3 cycles after acceptance.
REQ-040 Memory word 1 = 0x11223344; byte store of 0xAA to address 0x06 -> MEM_WD=0x11AA3344 in WR; a signed byte load from 0x06 then returns 0xFFFFFFAA, and an unsigned byte load returns 0x000000AA.
REQ-041 Signed half load from 0x06 with memory word 1 = 0x80013344 -> RSP_RDATA=0xFFFF8001; the same load from address 0x05 -> RSP_ERR=1, RSP_RDATA=0, no MEM_A activity, response 1 cycle after acceptance.
REQ-042 RSP_READY held 0 for 5 cycles after RSP_VALID rises -> RSP_RDATA and RSP_ERR remain stable, REQ_READY stays 0, and REQ_VALID pulses are ignored.
REQ-043 RST asserted during WAIT of a byte store -> MEM_WE never rises, no RSP_VALID, REQ_READY=1 the cycle after RST falls, and the memory word is unchanged.
REQ-044 With LSU_SUBWORD_EN undefined, a byte load from 0x04 -> RSP_ERR=1 with no memory access.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between a request/response handshake and a registered-read data memory.
// Byte/half accesses (incl. read-modify-write stores) are built only when LSU_SUBWORD_EN is defined.
module load_store_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WRITE,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_SIGNED,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        MEM_WE,
    output logic [31:0] MEM_A,
    output logic [31:0] MEM_WD,
    input  logic [31:0] MEM_RD
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        req_err;
    logic        write_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data;
    logic [31:0] store_data;
    logic [31:0] word_addr;

    assign accept    = REQ_VALID && REQ_READY;
    assign word_addr = {2'b00, addr_q[31:2]};

`ifdef LSU_SUBWORD_EN
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    logic [31:0] merge_q;
    logic [31:0] rmw_word;
    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign req_err = (REQ_SIZE == 2'b11)
                  || (REQ_SIZE == SZ_HALF && REQ_ADDR[0])
                  || (REQ_SIZE == SZ_WORD && REQ_ADDR[1:0] != 2'b00);

    // Little-endian lanes: byte n lives at bits [8n+7:8n].
    assign byte_shift = {addr_q[1:0], 3'b000};
    assign half_shift = {addr_q[1], 4'b0000};
    assign ld_byte    = MEM_RD[byte_shift +: 8];
    assign ld_half    = MEM_RD[half_shift +: 16];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        load_data = MEM_RD;
        case (size_q)
            SZ_BYTE: load_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: load_data = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

    always_comb begin
        rmw_word = MEM_RD;
        if (size_q == SZ_BYTE) rmw_word[byte_shift +: 8]  = wdata_q[7:0];
        else                   rmw_word[half_shift +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge CLK) begin
        if (RST)                 merge_q <= 32'h0;
        else if (state == WAIT)  merge_q <= rmw_word;
    end

    assign store_data = (size_q == SZ_WORD) ? wdata_q : merge_q;
`else
    logic unused_subword;

    assign req_err        = (REQ_SIZE != SZ_WORD) || (REQ_ADDR[1:0] != 2'b00);
    assign load_data      = MEM_RD;
    assign store_data     = wdata_q;
    assign unused_subword = ^{signed_q, size_q, addr_q[1:0]};
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (REQ_VALID) begin
                    if (req_err)                             state_nxt = RESP;
                    else if (REQ_WRITE && REQ_SIZE == SZ_WORD) state_nxt = WR;
                    else                                     state_nxt = RD;
                end
            end
            RD:      state_nxt = WAIT;
            WAIT:    state_nxt = write_q ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    if (RSP_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        REQ_READY = 1'b0;
        RSP_VALID = 1'b0;
        MEM_WE    = 1'b0;
        MEM_A     = 32'h0;
        MEM_WD    = 32'h0;
        case (state)
            IDLE: REQ_READY = !RST;
            RD, WAIT: MEM_A = word_addr;
            WR: begin
                MEM_A  = word_addr;
                MEM_WE = !RST;
                MEM_WD = store_data;
            end
            RESP:    RSP_VALID = 1'b1;
            default: ;
        endcase
    end

    // Request fields are captured once at acceptance; the response data is built from them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            write_q   <= 1'b0;
            signed_q  <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            RSP_RDATA <= 32'h0;
            RSP_ERR   <= 1'b0;
        end else if (accept) begin
            write_q   <= REQ_WRITE;
            signed_q  <= REQ_SIGNED;
            size_q    <= REQ_SIZE;
            addr_q    <= REQ_ADDR;
            wdata_q   <= REQ_WDATA;
            RSP_RDATA <= 32'h0;
            RSP_ERR   <= req_err;
        end else if (state == WAIT && !write_q) begin
            RSP_RDATA <= load_data;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table with a response scoreboard, plus
// hand-written stall and reset-abandon sequences. Expectations follow LSU_SUBWORD_EN.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WRITE;
    logic [1:0]  REQ_SIZE;
    logic        REQ_SIGNED;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic        MEM_WE;
    logic [31:0] MEM_A;
    logic [31:0] MEM_WD;
    logic [31:0] MEM_RD;

`ifdef LSU_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    always #5 CLK = ~CLK;

    load_store_unit dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_SIZE(REQ_SIZE), .REQ_SIGNED(REQ_SIGNED), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .MEM_WE(MEM_WE),
        .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
    );

    // Registered-read data memory, preset while mem_preset is high.
    logic [31:0] mem [0:63];
    logic [31:0] mem_rd_q;
    logic        mem_preset;

    always @(posedge CLK) begin
        if (mem_preset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[1] <= 32'h11223344;
            mem[2] <= 32'h01020304;
        end else if (MEM_WE === 1'b1) begin
            mem[MEM_A[5:0]] <= MEM_WD;
        end
        mem_rd_q <= mem[MEM_A[5:0]];
    end
    assign MEM_RD = mem_rd_q;

    // Bus activity monitor, sampled on the active edge.
    int          we_count  = 0;
    int          acc_count = 0;
    int          rv_count  = 0;
    logic [31:0] last_wd   = 32'h0;
    logic [31:0] last_a    = 32'h0;

    always @(posedge CLK) begin
        if (MEM_WE === 1'b1) begin
            we_count++;
            last_wd = MEM_WD;
        end
        if (MEM_A !== 32'h0) begin
            acc_count++;
            last_a = MEM_A;
        end
        if (RSP_VALID === 1'b1) rv_count++;
    end

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_lat;
        logic        exp_we;
        logic [31:0] exp_wd;
        logic [3:0]  exp_acc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Expected response from the access rules: rdata/wd are the legal-access results.
    function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic s,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rdata, input logic [31:0] mem_wd);
        vec_t v;
        logic legal;
        case (sz)
            2'b10:   legal = (a[1:0] == 2'b00);
            2'b01:   legal = SUBWORD && !a[0];
            2'b00:   legal = SUBWORD;
            default: legal = 1'b0;
        endcase
        v.write     = w;
        v.size      = sz;
        v.sgn       = s;
        v.addr      = a;
        v.wdata     = wd;
        v.exp_err   = !legal;
        v.exp_rdata = (!legal || w) ? 32'h0 : rdata;
        v.exp_we    = w && legal;
        v.exp_wd    = mem_wd;
        v.exp_lat   = !legal ? 4'd1 : !w ? 4'd3 : (sz == 2'b10) ? 4'd2 : 4'd4;
        v.exp_acc   = !legal ? 4'd0 : v.exp_lat - 4'd1;
        return v;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (REQ_READY !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) check("ready_timeout", {31'b0, REQ_READY}, 32'h1);
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic s,
                         input logic [31:0] a, input logic [31:0] wd);
        REQ_VALID  = 1'b1;
        REQ_WRITE  = w;
        REQ_SIZE   = sz;
        REQ_SIGNED = s;
        REQ_ADDR   = a;
        REQ_WDATA  = wd;
    endtask

    // Called at the negedge after acceptance; returns the cycle count to RSP_VALID.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (RSP_VALID !== 1'b1 && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   lat;
        int   we0;
        int   acc0;
        vec_t e;
        wait_ready();
        drive(v.write, v.size, v.sgn, v.addr, v.wdata);
        sb.push_back(v);
        we0  = we_count;
        acc0 = acc_count;
        @(negedge CLK);
        // Scramble the inputs after acceptance; the operation must use the latched copy.
        REQ_VALID  = 1'b0;
        REQ_WRITE  = ~v.write;
        REQ_SIZE   = ~v.size;
        REQ_SIGNED = ~v.sgn;
        REQ_ADDR   = ~v.addr;
        REQ_WDATA  = ~v.wdata;
        wait_rsp(lat);
        e = sb.pop_front();
        check("latency", lat, {28'b0, e.exp_lat});
        check("rsp_rdata", RSP_RDATA, e.exp_rdata);
        check("rsp_err", {31'b0, RSP_ERR}, {31'b0, e.exp_err});
        @(negedge CLK);
        check("idle_after_rsp", {31'b0, REQ_READY}, 32'h1);
        check("we_cycles", we_count - we0, {31'b0, e.exp_we});
        check("mem_a_cycles", acc_count - acc0, {28'b0, e.exp_acc});
        if (e.exp_acc != 0) check("mem_a", last_a, {2'b00, e.addr[31:2]});
        if (e.exp_we) check("mem_wd", last_wd, e.exp_wd);
    endtask

    initial begin
        int lat;
        int we0;
        int rv0;
        RST        = 1'b1;
        mem_preset = 1'b1;
        RSP_READY  = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        REQ_VALID  = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_req_ready", {31'b0, REQ_READY}, 32'h0);
        check("rst_rsp_valid", {31'b0, RSP_VALID}, 32'h0);
        check("rst_rsp_rdata", RSP_RDATA, 32'h0);
        check("rst_rsp_err", {31'b0, RSP_ERR}, 32'h0);
        check("rst_mem_we", {31'b0, MEM_WE}, 32'h0);
        check("rst_mem_a", MEM_A, 32'h0);
        mem_preset = 1'b0;
        RST        = 1'b0;
        #1;
        check("ready_at_rst_fall", {31'b0, REQ_READY}, 32'h1);
        @(negedge CLK);
        check("ready_after_rst", {31'b0, REQ_READY}, 32'h1);

        //                w     size   sgn   addr         wdata         rdata          mem_wd
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h06, 32'h123456AA, 32'h0,        32'h11AA3344));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h06, 32'h0,        32'hFFFFFFAA, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h06, 32'h0,        32'h000000AA, 32'h0));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h04, 32'h80013344, 32'h0,        32'h80013344));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h06, 32'h0,        32'hFFFF8001, 32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h05, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h06, 32'h0,        32'h00008001, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h04, 32'h0,        32'h00000044, 32'h0));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h04, 32'hFFFFBEEF, 32'h0,        32'h8001BEEF));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h04, 32'h0,
                          SUBWORD ? 32'h8001BEEF : 32'h80013344, 32'h0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h06, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h08, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h07, 32'h0000005A, 32'h0,        32'h5A01BEEF));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h05, 32'h0,        32'hFFFFFFBE, 32'h0));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h12, 32'h0BADF00D, 32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 32'h0));
        foreach (vecs[i]) run_vec(vecs[i]);

        // Response stall: outputs hold, no new request is taken, nothing is written.
        wait_ready();
        RSP_READY = 1'b0;
        drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        we0 = we_count;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        wait_rsp(lat);
        check("stall_latency", lat, 32'd3);
        for (int k = 0; k < 5; k++) begin
            check("stall_rdata", RSP_RDATA, 32'hDEADBEEF);
            check("stall_err", {31'b0, RSP_ERR}, 32'h0);
            check("stall_valid", {31'b0, RSP_VALID}, 32'h1);
            check("stall_req_ready", {31'b0, REQ_READY}, 32'h0);
            drive(1'b1, 2'b10, 1'b0, 32'h10, 32'h0BADF00D);
            REQ_VALID = (k % 2 == 0);
            @(negedge CLK);
        end
        RSP_READY = 1'b1;
        REQ_VALID = 1'b1;
        @(negedge CLK);
        check("no_accept_on_rsp", {31'b0, REQ_READY}, 32'h1);
        check("rsp_dropped", {31'b0, RSP_VALID}, 32'h0);
        REQ_VALID = 1'b0;
        @(negedge CLK);
        check("stall_we_cycles", we_count - we0, 32'h0);
        check("stall_mem", mem[4], 32'hDEADBEEF);

        // Reset while waiting on memory read data abandons the operation.
        wait_ready();
        if (SUBWORD) drive(1'b1, 2'b00, 1'b0, 32'h08, 32'h00000077);
        else         drive(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
        we0 = we_count;
        rv0 = rv_count;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("wait_rst_mem_we", {31'b0, MEM_WE}, 32'h0);
        check("wait_rst_ready", {31'b0, REQ_READY}, 32'h0);
        repeat (2) @(negedge CLK);
        check("wait_rst_valid", {31'b0, RSP_VALID}, 32'h0);
        RST = 1'b0;
        #1;
        check("wait_rst_ready_fall", {31'b0, REQ_READY}, 32'h1);
        @(negedge CLK);
        check("wait_rst_ready_next", {31'b0, REQ_READY}, 32'h1);
        repeat (3) @(negedge CLK);
        check("wait_rst_we_cycles", we_count - we0, 32'h0);
        check("wait_rst_rsp_cycles", rv_count - rv0, 32'h0);
        check("wait_rst_mem", mem[2], 32'h01020304);

        // Reset during the write cycle must kill the write enable at once.
        wait_ready();
        drive(1'b1, 2'b10, 1'b0, 32'h08, 32'hCAFEF00D);
        we0 = we_count;
        rv0 = rv_count;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        check("wr_mem_we", {31'b0, MEM_WE}, 32'h1);
        check("wr_mem_a", MEM_A, 32'h2);
        RST = 1'b1;
        #1;
        check("wr_rst_mem_we", {31'b0, MEM_WE}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("wr_rst_we_cycles", we_count - we0, 32'h0);
        check("wr_rst_rsp_cycles", rv_count - rv0, 32'h0);
        check("wr_rst_mem", mem[2], 32'h01020304);
        check("wr_rst_ready", {31'b0, REQ_READY}, 32'h1);

        run_vec(mk(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h01020304, 32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
